// File: rtl/expr_seq_if.sv
// expr_seq_if: token, ALU and result signals between the expression sequencer and its neighbours
interface expr_seq_if #(parameter int WIDTH = 32);
    logic             token_valid;
    logic             token_ready;
    logic             token_is_number;
    logic [WIDTH-1:0] token_value;
    logic [3:0]       token_op;
    logic             alu_start;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_div_zero;
    logic             result_valid;
    logic [WIDTH-1:0] result;
    logic             error;
    logic [1:0]       error_code;
    modport master (
        output token_valid, token_is_number, token_value, token_op, alu_done, alu_result, alu_div_zero,
        input  token_ready, alu_start, alu_op, alu_a, alu_b, result_valid, result, error, error_code
    );
    modport slave (
        input  token_valid, token_is_number, token_value, token_op, alu_done, alu_result, alu_div_zero,
        output token_ready, alu_start, alu_op, alu_a, alu_b, result_valid, result, error, error_code
    );
endinterface

// File: rtl/expr_sequencer.sv
// expr_sequencer: shunting-yard infix sequencer issuing one ALU operation at a time
module expr_sequencer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int OP_DEPTH = 8
) (
    input logic       clock,
    input logic       reset,
    expr_seq_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(OP_DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int QW = $clog2(OP_DEPTH);
    localparam logic [2:0] ACCEPT = 3'd0, CHECK = 3'd1, ISSUE = 3'd2, WAIT = 3'd3, DONE = 3'd4, ERR = 3'd5;
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_MUL = 4'd3, OP_DIV = 4'd4;
    localparam logic [3:0] OP_LP = 4'd5, OP_RP = 4'd6, OP_EQ = 4'd14;
    logic [2:0]       state_q, state_d;
    logic [SW-1:0]    osp_q, osp_d;
    logic [PW-1:0]    psp_q, psp_d;
    logic [WIDTH-1:0] opnd_q [DEPTH];
    logic [WIDTH-1:0] opnd_d [DEPTH];
    logic [3:0]       ops_q [OP_DEPTH];
    logic [3:0]       ops_d [OP_DEPTH];
    logic             expect_q, expect_d;
    logic [3:0]       pend_q, pend_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AW-1:0]    ia, ib;
    logic [QW-1:0]    it;
    logic [3:0]       top_op;
    logic             top_arith, take, busy, tok_op, tok_close;
    function automatic logic [1:0] prec(input logic [3:0] op);
        return (op == OP_ADD || op == OP_SUB) ? 2'd1 : (op == OP_MUL || op == OP_DIV) ? 2'd2 : 2'd0;
    endfunction
    assign ia        = AW'(osp_q - SW'(1));
    assign ib        = AW'(osp_q - SW'(2));
    assign it        = QW'(psp_q - PW'(1));
    assign top_op    = ops_q[it];
    assign top_arith = psp_q != '0 && prec(top_op) != 2'd0;
    assign take      = bus.token_valid && bus.token_ready;
    assign busy      = state_q == ISSUE || state_q == WAIT;
    assign tok_op    = !bus.token_is_number;
    assign tok_close = prec(bus.token_op) != 2'd0 || bus.token_op == OP_RP || bus.token_op == OP_EQ;
    assign bus.token_ready  = state_q == ACCEPT || state_q == ERR;
    assign bus.alu_start    = state_q == ISSUE;
    assign bus.alu_op       = busy ? top_op : '0;
    assign bus.alu_a        = busy ? opnd_q[ib] : '0;
    assign bus.alu_b        = busy ? opnd_q[ia] : '0;
    assign bus.result_valid = state_q == DONE;
    assign bus.result       = result_q;
    assign bus.error        = state_q == ERR;
    assign bus.error_code   = err_q;
    always_comb begin
        state_d  = state_q;
        osp_d    = osp_q;
        psp_d    = psp_q;
        opnd_d   = opnd_q;
        ops_d    = ops_q;
        expect_d = expect_q;
        pend_d   = pend_q;
        err_d    = err_q;
        result_d = result_q;
        case (state_q)
            ACCEPT: if (take) begin
                if (bus.token_is_number && expect_q) begin
                    if (osp_q == SW'(DEPTH)) begin state_d = ERR; err_d = 2'd2; end
                    else begin opnd_d[AW'(osp_q)] = bus.token_value; osp_d = osp_q + SW'(1); expect_d = 1'b0; end
                end else if (tok_op && bus.token_op == OP_LP && expect_q) begin
                    if (psp_q == PW'(OP_DEPTH)) begin state_d = ERR; err_d = 2'd2; end
                    else begin ops_d[QW'(psp_q)] = OP_LP; psp_d = psp_q + PW'(1); end
                end else if (tok_op && !expect_q && tok_close) begin
                    pend_d  = bus.token_op;
                    state_d = CHECK;
                end else begin
                    state_d = ERR;
                    err_d   = 2'd1;
                end
            end
            // RPAREN/EQUAL have precedence 0, so any arithmetic top reduces for them
            CHECK: if (top_arith && prec(top_op) >= prec(pend_q)) state_d = ISSUE;
            else if (pend_q == OP_RP) begin
                if (psp_q == '0) begin state_d = ERR; err_d = 2'd1; end
                else begin psp_d = psp_q - PW'(1); state_d = ACCEPT; end
            end else if (pend_q == OP_EQ) begin
                if (psp_q != '0) begin state_d = ERR; err_d = 2'd1; end
                else begin result_d = opnd_q[0]; state_d = DONE; end
            end else if (psp_q == PW'(OP_DEPTH)) begin
                state_d = ERR;
                err_d   = 2'd2;
            end else begin
                ops_d[QW'(psp_q)] = pend_q;
                psp_d    = psp_q + PW'(1);
                expect_d = 1'b1;
                state_d  = ACCEPT;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bus.alu_done) begin
                if (bus.alu_div_zero) begin state_d = ERR; err_d = 2'd3; end
                else begin
                    opnd_d[ib] = bus.alu_result;
                    osp_d      = osp_q - SW'(1);
                    psp_d      = psp_q - PW'(1);
                    state_d    = CHECK;
                end
            end
            DONE: begin
                osp_d    = '0;
                psp_d    = '0;
                expect_d = 1'b1;
                state_d  = ACCEPT;
            end
            ERR: if (take && tok_op && bus.token_op == OP_EQ) begin
                osp_d    = '0;
                psp_d    = '0;
                expect_d = 1'b1;
                err_d    = 2'd0;
                state_d  = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ACCEPT;
            osp_q    <= '0;
            psp_q    <= '0;
            expect_q <= 1'b1;
            pend_q   <= '0;
            err_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            osp_q    <= osp_d;
            psp_q    <= psp_d;
            expect_q <= expect_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end
    always_ff @(posedge clock) begin
        opnd_q <= opnd_d;
        ops_q  <= ops_d;
    end
endmodule

// File: tb/tb_expr_sequencer.sv
// tb_expr_sequencer: table-driven expression vectors plus latency and reset-in-WAIT sequences
module tb_expr_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    expr_seq_if #(.WIDTH(32)) bus();
    expr_sequencer #(.WIDTH(32), .DEPTH(8), .OP_DEPTH(8)) dut (.clock(clk), .reset(rst_n), .bus(bus));
    typedef struct {
        string       s;
        logic [31:0] res;
        int          ec;
        int          n;
        logic [3:0]  op0;
        logic [31:0] a0, b0;
        logic [3:0]  opl;
        logic [31:0] al, bl;
    } vec_t;
    int total = 0, bad = 0;
    int cyc = 0, inj_at = -1, logn = 0, res_cnt = 0, err_cnt = 0;
    bit alu_en = 1'b1;
    logic [31:0] last_res = '0;
    logic [3:0]  log_op [256];
    logic [31:0] log_a [256];
    logic [31:0] log_b [256];
    logic        apend = 1'b0;
    logic        pdz = 1'b0;
    logic [31:0] pres = '0;
    vec_t vt [19];
    // ALU model with one-cycle latency, plus result/error monitor
    always @(negedge clk) begin
        cyc++;
        bus.alu_done = 1'b0;
        bus.alu_div_zero = 1'b0;
        bus.alu_result = '0;
        if (apend) begin
            bus.alu_done = 1'b1;
            bus.alu_result = pres;
            bus.alu_div_zero = pdz;
            apend = 1'b0;
        end
        if (cyc == inj_at) begin
            bus.alu_done = 1'b1;
            bus.alu_result = 32'd99;
        end
        if (bus.alu_start && alu_en) begin
            log_op[logn[7:0]] = bus.alu_op;
            log_a[logn[7:0]] = bus.alu_a;
            log_b[logn[7:0]] = bus.alu_b;
            pdz = bus.alu_op == 4'd4 && bus.alu_b == 32'd0;
            pres = bus.alu_op == 4'd1 ? bus.alu_a + bus.alu_b :
                   bus.alu_op == 4'd2 ? bus.alu_a - bus.alu_b :
                   bus.alu_op == 4'd3 ? bus.alu_a * bus.alu_b :
                   pdz ? 32'd0 : bus.alu_a / bus.alu_b;
            apend = 1'b1;
            logn++;
        end
        if (bus.result_valid) begin
            res_cnt++;
            last_res = bus.result;
        end
        if (bus.error) err_cnt++;
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    function automatic logic [3:0] opcode(input byte c);
        case (c)
            "+": return 4'd1;
            "-": return 4'd2;
            "*": return 4'd3;
            "/": return 4'd4;
            "(": return 4'd5;
            ")": return 4'd6;
            "=": return 4'd14;
            default: return 4'd9;
        endcase
    endfunction
    task automatic send(input byte c);
        int k = 0;
        bus.token_is_number = c >= "0" && c <= "9";
        bus.token_value = bus.token_is_number ? 32'(c - "0") : 32'd0;
        bus.token_op = bus.token_is_number ? 4'd0 : opcode(c);
        bus.token_valid = 1'b1;
        while (!bus.token_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            total++;
            bad++;
            $display("FAIL token_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
        @(negedge clk);
        bus.token_valid = 1'b0;
    endtask
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask
    function automatic vec_t mk(input string s, input logic [31:0] res, input int ec, input int n,
                                input int op0, input int a0, input int b0, input int opl, input int al, input int bl);
        vec_t v;
        v.s = s; v.res = res; v.ec = ec; v.n = n;
        v.op0 = 4'(op0); v.a0 = a0; v.b0 = b0;
        v.opl = 4'(opl); v.al = al; v.bl = bl;
        return v;
    endfunction
    task automatic run_vec(input int i, input vec_t v);
        int lb = logn, rb = res_cnt, eb = err_cnt, f, l;
        string nm = $sformatf("v%0d[%s]", i, v.s);
        send_str(v.s);
        repeat (20) @(negedge clk);
        check({nm, "_code"}, 32'(bus.error_code), v.ec);
        check({nm, "_err"}, 32'(bus.error), 32'(v.ec != 0));
        check({nm, "_nalu"}, logn - lb, v.n);
        if (v.n > 0) begin
            f = lb & 255;
            l = (logn - 1) & 255;
            check({nm, "_op0"}, 32'(log_op[f]), 32'(v.op0));
            check({nm, "_a0"}, log_a[f], v.a0);
            check({nm, "_b0"}, log_b[f], v.b0);
            check({nm, "_opl"}, 32'(log_op[l]), 32'(v.opl));
            check({nm, "_al"}, log_a[l], v.al);
            check({nm, "_bl"}, log_b[l], v.bl);
        end
        if (v.ec == 0) begin
            check({nm, "_nres"}, res_cnt - rb, 1);
            check({nm, "_res"}, last_res, v.res);
            check({nm, "_errcyc"}, err_cnt - eb, 0);
        end else begin
            send_str("3+=");
            check({nm, "_clr_err"}, 32'(bus.error), 0);
            check({nm, "_clr_code"}, 32'(bus.error_code), 0);
            check({nm, "_nres"}, res_cnt - rb, 0);
        end
    endtask
    task automatic check_idle(input string nm);
        check({nm, "_ready"}, 32'(bus.token_ready), 1);
        check({nm, "_start"}, 32'(bus.alu_start), 0);
        check({nm, "_op"}, 32'(bus.alu_op), 0);
        check({nm, "_a"}, bus.alu_a, 0);
        check({nm, "_b"}, bus.alu_b, 0);
        check({nm, "_rv"}, 32'(bus.result_valid), 0);
        check({nm, "_res"}, bus.result, 0);
        check({nm, "_err"}, 32'(bus.error), 0);
        check({nm, "_code"}, 32'(bus.error_code), 0);
    endtask
    initial begin
        int k, rb, eb;
        bus.token_valid = 1'b0;
        bus.token_is_number = 1'b0;
        bus.token_value = '0;
        bus.token_op = '0;
        vt[0]  = mk("2+3*4=", 14, 0, 2, 3, 3, 4, 1, 2, 12);
        vt[1]  = mk("8-3-2=", 3, 0, 2, 2, 8, 3, 2, 5, 2);
        vt[2]  = mk("(1+2)*3=", 9, 0, 2, 1, 1, 2, 3, 3, 3);
        vt[3]  = mk("7=", 7, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[4]  = mk("9-4*2=", 1, 0, 2, 3, 4, 2, 2, 9, 8);
        vt[5]  = mk("6/2*3=", 9, 0, 2, 4, 6, 2, 3, 3, 3);
        vt[6]  = mk("((2))=", 2, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[7]  = mk("5/0=", 0, 3, 1, 4, 5, 0, 4, 5, 0);
        vt[8]  = mk("4+4=", 8, 0, 1, 1, 4, 4, 1, 4, 4);
        vt[9]  = mk("+", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[10] = mk("1)", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[11] = mk("(1=", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[12] = mk("11", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[13] = mk("1?", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vt[14] = mk("(((((((((", 0, 2, 0, 0, 0, 0, 0, 0, 0);
        vt[15] = mk("((((((((1))))))))=", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[16] = mk("2*(3+4)-5=", 9, 0, 3, 1, 3, 4, 2, 14, 5);
        vt[17] = mk("3-5=", 32'hFFFF_FFFE, 0, 1, 2, 3, 5, 2, 3, 5);
        vt[18] = mk("1+(2*(3+4))=", 15, 0, 3, 1, 3, 4, 1, 1, 14);
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 19; i++) run_vec(i, vt[i]);
        send("7");
        send("=");
        check("eq_lat_c1", 32'(bus.result_valid), 0);
        @(negedge clk);
        check("eq_lat_c2", 32'(bus.result_valid), 1);
        check("eq_lat_res", bus.result, 7);
        @(negedge clk);
        check("eq_lat_pulse", 32'(bus.result_valid), 0);
        send("1");
        send("+");
        check("op_lat_c1", 32'(bus.token_ready), 0);
        @(negedge clk);
        check("op_lat_c2", 32'(bus.token_ready), 1);
        send_str("2=");
        repeat (20) @(negedge clk);
        check("op_lat_res", last_res, 3);
        alu_en = 1'b0;
        send_str("2+3=");
        k = 0;
        while (!bus.alu_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("wait_reached", 32'(bus.alu_start), 1);
        @(negedge clk);
        check("wait_op", 32'(bus.alu_op), 1);
        check("wait_a", bus.alu_a, 2);
        check("wait_b", bus.alu_b, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("rst_wait");
        rst_n = 1'b1;
        rb = res_cnt;
        eb = err_cnt;
        inj_at = cyc + 2;
        repeat (5) @(negedge clk);
        alu_en = 1'b1;
        check("late_done_nres", res_cnt - rb, 0);
        check("late_done_err", err_cnt - eb, 0);
        check("late_done_ready", 32'(bus.token_ready), 1);
        send_str("4=");
        repeat (20) @(negedge clk);
        check("post_rst_nres", res_cnt - rb, 1);
        check("post_rst_res", last_res, 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
